// File: rtl/data_addr_gen_if.sv
// Handshake and bus signals between the walk controller
// and the SRAM row-address generator.
interface data_addr_gen_if;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] num_rows;
    logic       ready_in;
    logic [7:0] addr_1_out;
    logic [7:0] addr_2_out;
    logic       package_1_valid_out;
    logic       package_2_valid_out;
    logic [6:0] tile_idx_out;
    logic       busy;
    logic       done;

    modport master (
        output start, base_addr, num_rows, ready_in,
        input  addr_1_out, addr_2_out,
        input  package_1_valid_out, package_2_valid_out,
        input  tile_idx_out, busy, done
    );

    modport slave (
        input  start, base_addr, num_rows, ready_in,
        output addr_1_out, addr_2_out,
        output package_1_valid_out, package_2_valid_out,
        output tile_idx_out, busy, done
    );
endinterface

// File: rtl/data_addr_gen.sv
// Dual-port SRAM row-address generator: walks a feature map
// as overlapping 4-row tiles, two rows per package pair.
module data_addr_gen (
    input  logic           clk,
    input  logic           reset,
    input  logic           scan_mode,
    data_addr_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE_LO,
        ISSUE_HI,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] base_q;
    logic [7:0] r_q;
    logic [7:0] tiles_q;
    logic [6:0] tile_q;
    logic [7:0] addr_1_q;
    logic [7:0] addr_2_q;
    logic       valid_q;
    logic [6:0] tile_idx_q;
    logic       busy_q;
    logic       done_q;

    logic [7:0] t_calc;
    logic [7:0] addr_p2;
    logic [7:0] addr_p3;
    logic [6:0] tile_nx;
    logic       more;

    // Tiles overlap by two rows; an odd trailing row is dropped.
    assign t_calc  = (bus.num_rows >= 8'd4)
                   ? ((bus.num_rows - 8'd2) >> 1) : 8'd0;
    assign addr_p2 = base_q + r_q + 8'd2;
    assign addr_p3 = base_q + r_q + 8'd3;
    assign tile_nx = tile_q + 7'd1;
    assign more    = ({1'b0, tile_nx} < tiles_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            base_q     <= 8'd0;
            r_q        <= 8'd0;
            tiles_q    <= 8'd0;
            tile_q     <= 7'd0;
            addr_1_q   <= 8'd0;
            addr_2_q   <= 8'd0;
            valid_q    <= 1'b0;
            tile_idx_q <= 7'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !scan_mode) begin
                        base_q  <= bus.base_addr;
                        tiles_q <= t_calc;
                        r_q     <= 8'd0;
                        tile_q  <= 7'd0;
                        if (t_calc != 8'd0) begin
                            state      <= ISSUE_LO;
                            addr_1_q   <= bus.base_addr;
                            addr_2_q   <= bus.base_addr + 8'd1;
                            valid_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            tile_idx_q <= 7'd0;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ISSUE_LO: begin
                    if (scan_mode) begin
                        state      <= IDLE;
                        valid_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        tile_idx_q <= 7'd0;
                    end else if (bus.ready_in) begin
                        state    <= ISSUE_HI;
                        addr_1_q <= addr_p2;
                        addr_2_q <= addr_p3;
                    end
                end
                ISSUE_HI: begin
                    if (scan_mode) begin
                        state      <= IDLE;
                        valid_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        tile_idx_q <= 7'd0;
                    end else if (bus.ready_in) begin
                        r_q    <= r_q + 8'd2;
                        tile_q <= tile_nx;
                        if (more) begin
                            // Next tile's low pair repeats this high pair.
                            state      <= ISSUE_LO;
                            addr_1_q   <= addr_p2;
                            addr_2_q   <= addr_p3;
                            tile_idx_q <= tile_nx;
                        end else begin
                            state      <= DONE;
                            valid_q    <= 1'b0;
                            busy_q     <= 1'b0;
                            tile_idx_q <= 7'd0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.addr_1_out          = addr_1_q;
    assign bus.addr_2_out          = addr_2_q;
    assign bus.package_1_valid_out = valid_q;
    assign bus.package_2_valid_out = valid_q;
    assign bus.tile_idx_out        = tile_idx_q;
    assign bus.busy                = busy_q;
    assign bus.done                = done_q;
endmodule

// File: tb/tb_data_addr_gen.sv
// Directed bench for data_addr_gen with an expected-pair
// scoreboard popped on every transfer.
module tb_data_addr_gen;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scan_mode = 1'b0;

    data_addr_gen_if ifc ();

    data_addr_gen dut (
        .clk       (clk),
        .reset     (reset),
        .scan_mode (scan_mode),
        .bus       (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a1;
        logic [7:0] a2;
        logic [6:0] tile;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_walk(input logic [7:0] b, input int rows);
        int         t;
        logic [7:0] o;
        exp_t       e;
        t = (rows >= 4) ? (rows - 2) / 2 : 0;
        for (int i = 0; i < t; i++) begin
            o      = 8'(2 * i);
            e.a1   = b + o;
            e.a2   = b + o + 8'd1;
            e.tile = 7'(i);
            q.push_back(e);
            e.a1   = b + o + 8'd2;
            e.a2   = b + o + 8'd3;
            q.push_back(e);
        end
    endtask

    // Drive at negedge, clock once, observe at the next negedge.
    task automatic tick(input logic rdy);
        bit   xfer;
        exp_t e;
        ifc.ready_in = rdy;
        xfer = ifc.package_1_valid_out && rdy && !scan_mode && reset;
        @(posedge clk);
        if (xfer && q.size() > 0) void'(q.pop_front());
        @(negedge clk);
        if (ifc.done) done_cnt++;
        if (ifc.busy) busy_cnt++;
        chk("valid_eq", 32'(ifc.package_2_valid_out),
            32'(ifc.package_1_valid_out));
        if (ifc.package_1_valid_out) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = q[0];
                chk("addr_1", 32'(ifc.addr_1_out), 32'(e.a1));
                chk("addr_2", 32'(ifc.addr_2_out), 32'(e.a2));
                chk("tile_idx", 32'(ifc.tile_idx_out), 32'(e.tile));
            end
        end else begin
            chk("tile_idle", 32'(ifc.tile_idx_out), 32'd0);
        end
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] r);
        ifc.base_addr = b;
        ifc.num_rows  = r;
        ifc.start     = 1'b1;
        tick(1'b1);
        ifc.start     = 1'b0;
        ifc.base_addr = 8'hAA;
        ifc.num_rows  = 8'd0;
    endtask

    task automatic drain(input int max, output int n);
        n = 0;
        while (q.size() > 0 && n < max) begin
            tick(1'b1);
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a1"}, 32'(ifc.addr_1_out), 32'd0);
        chk({tag, "_a2"}, 32'(ifc.addr_2_out), 32'd0);
        chk({tag, "_v1"}, 32'(ifc.package_1_valid_out), 32'd0);
        chk({tag, "_v2"}, 32'(ifc.package_2_valid_out), 32'd0);
        chk({tag, "_tile"}, 32'(ifc.tile_idx_out), 32'd0);
        chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
        chk({tag, "_done"}, 32'(ifc.done), 32'd0);
    endtask

    initial begin
        int n;
        int d0;
        int b0;
        ifc.start     = 1'b0;
        ifc.base_addr = 8'd0;
        ifc.num_rows  = 8'd0;
        ifc.ready_in  = 1'b0;

        #3;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1);
        tick(1'b1);

        // Six rows: two overlapping tiles back to back.
        d0 = done_cnt;
        push_walk(8'h10, 6);
        do_start(8'h10, 8'd6);
        chk("first_valid", 32'(ifc.package_1_valid_out), 32'd1);
        chk("busy_walk", 32'(ifc.busy), 32'd1);
        drain(20, n);
        chk("walk6_cycles", 32'(n), 32'd4);
        chk("walk6_done", 32'(ifc.done), 32'd1);
        tick(1'b1);
        chk("done_one_cycle", 32'(ifc.done), 32'd0);
        chk("walk6_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Address wrap past 0xFF.
        d0 = done_cnt;
        push_walk(8'hFE, 4);
        do_start(8'hFE, 8'd4);
        drain(20, n);
        chk("wrap_cycles", 32'(n), 32'd2);
        tick(1'b1);
        chk("wrap_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Backpressure holds the second pair for three cycles.
        d0 = done_cnt;
        push_walk(8'h10, 6);
        do_start(8'h10, 8'd6);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        chk("held_a1", 32'(ifc.addr_1_out), 32'h12);
        chk("held_q", 32'(q.size()), 32'd3);
        drain(20, n);
        chk("bp_cycles", 32'(n), 32'd3);
        tick(1'b1);
        chk("bp_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Three rows: no tiles, immediate done.
        d0 = done_cnt;
        b0 = busy_cnt;
        do_start(8'h30, 8'd3);
        chk("rows3_done", 32'(ifc.done), 32'd1);
        chk("rows3_valid", 32'(ifc.package_1_valid_out), 32'd0);
        tick(1'b1);
        tick(1'b1);
        chk("rows3_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("rows3_busy", 32'(busy_cnt - b0), 32'd0);

        // Scan abort during the third pair.
        d0 = done_cnt;
        push_walk(8'h40, 6);
        do_start(8'h40, 8'd6);
        tick(1'b1);
        tick(1'b1);
        chk("pre_abort_a1", 32'(ifc.addr_1_out), 32'h42);
        scan_mode = 1'b1;
        tick(1'b1);
        q.delete();
        chk("abort_valid", 32'(ifc.package_1_valid_out), 32'd0);
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        b0 = busy_cnt;
        do_start(8'h50, 8'd8);
        chk("scan_start_valid", 32'(ifc.package_1_valid_out), 32'd0);
        tick(1'b1);
        tick(1'b1);
        chk("scan_done_cnt", 32'(done_cnt - d0), 32'd0);
        chk("scan_busy_cnt", 32'(busy_cnt - b0), 32'd0);
        scan_mode = 1'b0;
        tick(1'b1);

        // Asynchronous reset mid-walk, then a fresh walk.
        push_walk(8'h20, 8);
        do_start(8'h20, 8'd8);
        tick(1'b1);
        tick(1'b1);
        #2 reset = 1'b0;
        #1 chk_zero("async_rst");
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1);
        tick(1'b1);
        chk("post_rst_idle", 32'(ifc.package_1_valid_out), 32'd0);
        d0 = done_cnt;
        push_walk(8'h80, 4);
        do_start(8'h80, 8'd4);
        drain(20, n);
        chk("fresh_cycles", 32'(n), 32'd2);
        tick(1'b1);
        chk("fresh_done_cnt", 32'(done_cnt - d0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_addr_gen.md
DATA_ADDR_GEN -- requirements
Module: data_addr_gen

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle request to begin a feature-map walk; sampled only in IDLE.
REQ-004 base_addr  input  8  SRAM word address of row 0; captured on accepted start.
REQ-005 num_rows  input  8  feature-map height in SRAM rows; captured on accepted start.
REQ-006 scan_mode  input  1  memory preload in progress; blocks and aborts address generation.
REQ-007 ready_in  input  1  downstream accepts the current package pair this cycle.
REQ-008 addr_1_out  output  8  port-1 row address, registered.
REQ-009 addr_2_out  output  8  port-2 row address, registered.
REQ-010 package_1_valid_out  output  1  addr_1_out is valid, registered.
REQ-011 package_2_valid_out  output  1  addr_2_out is valid, registered.
REQ-012 tile_idx_out  output  7  index of the tile the current pair belongs to.
REQ-013 busy  output  1  high in ISSUE_LO and ISSUE_HI.
REQ-014 done  output  1  one-cycle pulse at walk completion.

Function
REQ-015 FSM states: IDLE, ISSUE_LO, ISSUE_HI, DONE.
REQ-016 Tile count T = floor((num_rows-2)/2) for num_rows>=4; T = 0 for num_rows<4; odd final row unused.
REQ-017 IDLE: start=1 and scan_mode=0 -> capture inputs, r=0, tile=0; next state ISSUE_LO if T>0, else DONE.
REQ-018 IDLE: start ignored while scan_mode=1.
REQ-019 ISSUE_LO drives addr_1=base+r, addr_2=base+r+1, both valids=1.
REQ-020 ISSUE_HI drives addr_1=base+r+2, addr_2=base+r+3, both valids=1.
REQ-021 Transfer occurs when valids=1 and ready_in=1; state advances only on transfer.
REQ-022 ready_in=0: state, addresses, valids, tile_idx_out held unchanged.
REQ-023 Transfer in ISSUE_LO -> ISSUE_HI.
REQ-024 Transfer in ISSUE_HI -> r+=2, tile+=1; next ISSUE_LO if tile+1<T, else DONE.
REQ-025 Latency: first pair valid the cycle after start is sampled; back-to-back pairs each cycle while ready_in=1.
REQ-026 Address arithmetic is 8-bit modulo 256; wrap past 0xFF to 0x00 is not an error.
REQ-027 Both valid outputs always equal; tile_idx_out = tile while busy, else 0.
REQ-028 DONE: done=1 and valids=0 for exactly one cycle, then IDLE.
REQ-029 scan_mode=1 in ISSUE_LO/ISSUE_HI -> next cycle IDLE, valids=0, no done pulse; pending pair discarded.
REQ-030 scan_mode has priority over ready_in in the same cycle.
REQ-031 start asserted while not in IDLE is ignored; captured inputs remain stable for the whole walk.

Reset
REQ-032 reset=0 forces IDLE immediately, asynchronously, including mid-walk.
REQ-033 Reset values: addr_1_out=0, addr_2_out=0, both valids=0, tile_idx_out=0, busy=0, done=0.
REQ-034 After reset release, no package issues until a new accepted start.

Verification
REQ-035 base=0x10, rows=6, ready_in=1 -> pairs (10,11),(12,13),(12,13),(14,15) on 4 consecutive cycles, tile_idx 0,0,1,1, then done pulse.
REQ-036 base=0xFE, rows=4 -> pairs (FE,FF),(00,01), then done.
REQ-037 rows=6, ready_in=0 for 3 cycles during second pair -> (12,13) held 3 cycles, sequence otherwise identical to REQ-035.
REQ-038 rows=3 -> no valid asserted; done one cycle after start, busy never high.
REQ-039 scan_mode=1 during third pair -> valids drop next cycle, no done, IDLE; start with scan_mode=1 ignored.
REQ-040 reset=0 mid-walk -> outputs zero asynchronously; fresh start with rows=4 yields (base,base+1),(base+2,base+3).
